// File: rtl/crc5_tx_serializer.sv
// rtl/crc5_tx_serializer.sv - word-in, serial-out frame of WIDTH data bits (LSB first) plus USB CRC5 (MSB first)
// Optional LAST_DOWN output marking the final CRC bit: define CRC5_TX_LAST_EN.
module crc5_tx_serializer #(
  parameter int WIDTH = 11
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DATA_UP,
  input  logic             VALID_UP,
  output logic             READY_UP,
  output logic             DATA_DOWN,
  output logic             VALID_DOWN,
  input  logic             READY_DOWN
`ifdef CRC5_TX_LAST_EN
  ,
  output logic             LAST_DOWN
`endif
);

  // Counter also walks the five CRC bits, so it never drops below 3 bits.
  localparam int CW0   = $clog2(WIDTH + 1);
  localparam int CNT_W = (CW0 < 3) ? 3 : CW0;
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_CRC  = CNT_W'(4);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [4:0]       crc_q, crc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       crc_sh;

  assign crc_sh = crc_q << cnt_q[2:0];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      sr_q    <= '0;
      crc_q   <= 5'b11111;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    READY_UP   = 1'b0;
    VALID_DOWN = 1'b0;
    DATA_DOWN  = 1'b0;
`ifdef CRC5_TX_LAST_EN
    LAST_DOWN  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        READY_UP = 1'b1;
        cnt_d    = '0;
        crc_d    = 5'b11111;
        if (VALID_UP) begin
          sr_d    = DATA_UP;
          state_d = DATA;
        end
      end
      DATA: begin
        VALID_DOWN = 1'b1;
        DATA_DOWN  = sr_q[0];
        if (READY_DOWN) begin
          sr_d  = sr_q >> 1;
          crc_d = {crc_q[3:0], 1'b0} ^ ((sr_q[0] ^ crc_q[4]) ? 5'b00101 : 5'b00000);
          if (cnt_q == LAST_DATA) begin
            cnt_d   = '0;
            state_d = CRC;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      CRC: begin
        VALID_DOWN = 1'b1;
        DATA_DOWN  = ~crc_sh[4];
`ifdef CRC5_TX_LAST_EN
        LAST_DOWN  = (cnt_q == LAST_CRC);
`endif
        if (READY_DOWN) begin
          if (cnt_q == LAST_CRC) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/crc5_tx_serializer.md
Name: crc5_tx_serializer

Overview:
- Transmit-side counterpart of the CRC5 receive path.
- Accepts one WIDTH-bit parallel word over a valid/ready handshake and computes the USB-style CRC5 (x^5+x^2+1) on the fly.
- Streams a serial frame downstream: WIDTH data bits LSB first, then 5 CRC bits MSB first, over a 1-bit valid/ready handshake.
- Sits between the word-level transmit source and the serial line driver.

Parameters:
- WIDTH, 11, payload bits per frame; legal range 1..64. Frame length is WIDTH+5 bits.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- DATA_UP  input  WIDTH  parallel payload word.
- VALID_UP  input  1  DATA_UP valid.
- READY_UP  output  1  block can accept a word.
- DATA_DOWN  output  1  serial bit.
- VALID_DOWN  output  1  DATA_DOWN valid.
- READY_DOWN  input  1  downstream accepts the bit.

Interface note: one clock; reset is synchronous and active-high.

Behaviour:
- Reset (RESET=1 at clock edge):
  - state=IDLE, READY_UP=1, VALID_DOWN=0, DATA_DOWN=0.
  - crc=5'b11111, bit counter=0, shift register=0.
  - Asserting RESET mid-frame aborts the frame with no further bits. Outputs take reset values from the next edge.
- States: IDLE, DATA, CRC. READY_UP=1 only in IDLE; VALID_DOWN=1 only in DATA and CRC. Both are decoded from registered state.
- IDLE:
  - On VALID_UP&&READY_UP, latch DATA_UP into the shift register and go to DATA.
  - Set bit counter=0 and crc=5'b11111.
  - First serial bit is valid in the cycle after acceptance (latency 1).
- DATA:
  - DATA_DOWN = shift_reg[0].
  - On VALID_DOWN&&READY_DOWN, shift right by 1 and update the CRC with bit b=shift_reg[0]: fb = b ^ crc[4]; crc <= {crc[3:0],1'b0} ^ (fb ? 5'b00101 : 5'b00000). Increment the counter.
  - On the handshake of bit WIDTH-1, go to CRC with counter=0.
- CRC:
  - DATA_DOWN = ~crc[4-counter], i.e. complemented remainder, MSB first.
  - Counter advances only on handshake.
  - On the handshake of CRC bit 4, go to IDLE.
- Stall: with READY_DOWN=0, DATA_DOWN, VALID_DOWN, crc and counter hold indefinitely.
- Throughput: one idle cycle between frames. READY_UP rises the cycle after the last CRC bit handshake, so the minimum frame period is WIDTH+6 cycles.
- Ignored upstream inputs: DATA_UP/VALID_UP are ignored outside IDLE, and a word is never accepted mid-frame.
- Widths: the counter is $clog2(WIDTH+1) bits minimum, and no wrap occurs inside a frame.

Optional Feature:
- Macro CRC5_TX_LAST_EN.
- Defined:
  - Adds output port LAST_DOWN (1 bit), equal to 1 exactly while the final CRC bit (CRC bit 4 position) is presented with VALID_DOWN=1, else 0.
  - LAST_DOWN resets to 0 and holds during stalls.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset check: assert RESET 3 cycles, then release -> READY_UP=1, VALID_DOWN=0, DATA_DOWN=0. No bit emitted while VALID_UP=0.
- All-zero frame: WIDTH=11, DATA_UP=11'h000 accepted with READY_DOWN=1 -> 11 zeros, then CRC bits 0,1,0,0,0 (~crc=5'h08). READY_UP returns 1 on cycle 17 after acceptance.
- All-ones frame: DATA_UP=11'h7FF -> 11 ones, then CRC bits 0,0,0,1,0 (~crc=5'h02). With CRC5_TX_LAST_EN, LAST_DOWN=1 only on the final bit.
- Backpressure: DATA_UP=11'h000, READY_DOWN toggled 1/0 each cycle -> same 16-bit sequence as the all-zero frame. Each bit is held stable while READY_DOWN=0, and the frame takes 32 cycles.
- Mid-frame abort: accept 11'h7FF, assert RESET after 6 data bits -> VALID_DOWN=0 next cycle. A following frame of 11'h000 yields CRC 0,1,0,0,0 with no residue from the aborted frame.
- Upstream ignored when busy: hold VALID_UP=1 with a new word during a frame -> READY_UP=0 throughout. The new word is accepted only in the cycle after the current frame's last CRC bit.
